ws2812b_rx: RTL and testbench
=============================

// Module: ws2812b_rx
// PURPOSE
//  Receive end of the WS2812B single-wire LED protocol. Samples a GRB pixel stream, decodes
//  each bit from its high-pulse width and assembles 24-bit pixels with their index in the frame.
//  Detects the latch (reset) gap as end of frame. Used as loop-back checker / chain tap beside
//  the strip driver on the 12 MHz board clock.
// PARAMETERS
//  BIT_THRESH    7    high-time cycles >= this decode as 1; below decode as 0 (0.58 us @12 MHz)
//  MIN_HIGH      2    high pulse shorter than this is a glitch -> error
//  MAX_HIGH      12   high pulse longer than this -> error
//  RESET_CYCLES  600  continuous low >= this is a latch gap (50 us @12 MHz)
//  PIX_W         6    pixel index width (64 pixels per frame)
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous, active-high reset
//  din           in   1      WS2812B serial line, asynchronous to clk
//  pixel_valid   out  1      one-cycle strobe: pixel_data/pixel_index valid
//  pixel_data    out  24     {green, red, blue}, MSB received first
//  pixel_index   out  PIX_W  position of pixel in current frame, 0 = first after latch
//  frame_done    out  1      one-cycle strobe when a latch gap completes
//  rx_error      out  1      one-cycle strobe on pulse-width violation or partial pixel
// BEHAVIOUR
//  - Reset: all outputs 0; bit count, index and counters cleared; FSM -> SYNC.
//  - din passes a 2-FF synchroniser; all timing below refers to the synchronised line (+2 cycles from pin).
//  - One width counter, saturating at RESET_CYCLES; clears on every synchronised edge.
//  - FSM:
//    - SYNC:  wait for RESET_CYCLES continuous low -> IDLE (no frame_done). High resets the count.
//    - IDLE:  rising edge -> HIGH.
//    - HIGH:  count high cycles.
//      - Falling edge with MIN_HIGH <= count <= MAX_HIGH: shift bit (count >= BIT_THRESH) into
//        the 24-bit shifter, bit_cnt++, -> LOW.
//      - Count reaching MAX_HIGH+1 while still high, or falling edge with count < MIN_HIGH:
//        rx_error pulse -> SYNC. Partial pixel discarded; index held until next latch.
//    - LOW:
//      - Rising edge before RESET_CYCLES -> HIGH (an inter-bit gap of any such length is legal).
//      - Count reaching RESET_CYCLES:
//        - frame_done pulse; pixel_index <= 0 -> IDLE.
//        - If bit_cnt != 0 also pulse rx_error and discard the bits.
//  - Pixel commit: falling edge that completes bit 24 in cycle N -> pixel_valid high in cycle N+1
//    only, with pixel_data and the current pixel_index.
//    - pixel_index increments in N+2.
//    - Wraps 2^PIX_W-1 -> 0 silently.
//    - bit_cnt returns to 0.
//  - pixel_data holds its last value between strobes; pixel_index holds between increments.
//  - pixel_valid and frame_done never coincide: a latch needs >= RESET_CYCLES after the last falling edge.
//  - rst mid-pixel or mid-gap: immediate clear; the following partial traffic is ignored until a full gap is seen in SYNC.
// STRUCTURE
//  - ws2812b_pkg (shared with the strip driver):
//    - typedef grb_t: packed struct {g, r, b} of 8-bit fields
//    - enum rx_state_t {SYNC, IDLE, HIGH, LOW}
//    - localparams for 12 MHz T0H/T1H/TBIT/TRESET cycle counts
//  - Sub-module ws2812b_pulse_meter: synchroniser, edge detect, saturating width counter.
//    Outputs rise/fall strobes + width. FSM and shifter stay in ws2812b_rx.
// TESTING
//  Bit encoding: '1' = 8 high / 7 low, '0' = 4 high / 11 low.
//  1. rst, 700 low, one pixel 24'hFF0000 -> single pixel_valid, pixel_data=24'hFF0000, pixel_index=0.
//  2. 64 pixels (value = index) then 600 low -> indices 0..63 in order with matching data;
//     frame_done once, exactly RESET_CYCLES after last fall; next pixel has index 0.
//  3. Threshold: high 6 -> bit 0, high 7 -> bit 1 (pixel 24'h000001 vs 24'h000000);
//     highs of 2 and 12 accepted.
//  4. High of 13 mid-pixel -> rx_error at count 13, no pixel_valid;
//     next frame accepted only after 600 low.
//     High of 1 -> rx_error likewise.
//  5. 10 bits then 600 low -> no pixel_valid; frame_done and rx_error same cycle.
//  6. rst asserted 1 cycle at bit 12 -> all outputs 0 next cycle;
//     rest of pixel ignored, no pixel_valid until gap + new pixel.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared WS2812B types and 12 MHz timing constants, used by both the strip driver and the receiver.
package ws2812b_pkg;
  localparam int CLK_HZ     = 12_000_000;
  localparam int T0H_CYC    = 4;
  localparam int T1H_CYC    = 8;
  localparam int TBIT_CYC   = 15;
  localparam int TRESET_CYC = 600;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} rx_state_t;
endpackage

// File: rtl/ws2812b_pulse_meter.sv
// Synchronises the WS2812B line and measures how long the current level has been held.
module ws2812b_pulse_meter #(
  parameter int RESET_CYCLES = 600,
  parameter int CNT_W        = $clog2(RESET_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] width
);
  logic meta, level_d;

  // width counts the edge cycle itself, so at a fall it equals the number of high cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta    <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      width   <= '0;
    end else begin
      meta    <= din;
      level   <= meta;
      level_d <= level;
      if (level != level_d)
        width <= CNT_W'(1);
      else if (width != CNT_W'(RESET_CYCLES))
        width <= width + CNT_W'(1);
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;
endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receiver: decodes bits from high-pulse width, assembles GRB pixels and flags latch gaps.
//   state | meaning
//   SYNC  | waiting for a full latch gap before trusting the line
//   IDLE  | frame boundary seen, waiting for the first rising edge
//   HIGH  | measuring a bit's high pulse
//   LOW   | between bits; a long enough low ends the frame
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int BIT_THRESH   = 7,
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 12,
  parameter int RESET_CYCLES = 600,
  parameter int PIX_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic             pixel_valid,
  output logic [23:0]      pixel_data,
  output logic [PIX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic             rx_error
);
  localparam int CNT_W = $clog2(RESET_CYCLES + 1);

  logic             level, rise, fall;
  logic [CNT_W-1:0] width;
  rx_state_t        state, state_next;
  logic [22:0]      shreg;
  logic [4:0]       bit_cnt;
  logic             bit_val, low_done;
  logic             shift_en, pix_done, err_next, frame_next, gap_sync, clr_bits;
  grb_t             pix_next;

  ws2812b_pulse_meter #(
    .RESET_CYCLES(RESET_CYCLES),
    .CNT_W       (CNT_W)
  ) u_meter (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .level(level),
    .rise (rise),
    .fall (fall),
    .width(width)
  );

  // width lags the level by one cycle, so RESET_CYCLES-1 here means RESET_CYCLES low cycles.
  assign low_done = ~level && (width >= CNT_W'(RESET_CYCLES - 1));
  assign bit_val  = (width >= CNT_W'(BIT_THRESH));
  assign pix_next = {shreg, bit_val};

  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    pix_done   = 1'b0;
    err_next   = 1'b0;
    frame_next = 1'b0;
    gap_sync   = 1'b0;
    clr_bits   = 1'b0;
    case (state)
      SYNC: begin
        if (low_done) begin
          state_next = IDLE;
          gap_sync   = 1'b1;
        end
      end
      IDLE: begin
        if (rise) state_next = HIGH;
      end
      HIGH: begin
        if (fall) begin
          if (width >= CNT_W'(MIN_HIGH) && width <= CNT_W'(MAX_HIGH)) begin
            shift_en   = 1'b1;
            pix_done   = (bit_cnt == 5'd23);
            state_next = LOW;
          end else begin
            err_next   = 1'b1;
            clr_bits   = 1'b1;
            state_next = SYNC;
          end
        end else if (width >= CNT_W'(MAX_HIGH)) begin
          err_next   = 1'b1;
          clr_bits   = 1'b1;
          state_next = SYNC;
        end
      end
      LOW: begin
        if (rise) begin
          state_next = HIGH;
        end else if (low_done) begin
          frame_next = 1'b1;
          err_next   = (bit_cnt != 5'd0);
          clr_bits   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      pixel_valid <= pix_done;
      frame_done  <= frame_next;
      rx_error    <= err_next;
      if (shift_en) begin
        shreg   <= pix_next[22:0];
        bit_cnt <= pix_done ? 5'd0 : bit_cnt + 5'd1;
      end
      if (clr_bits) bit_cnt <= 5'd0;
      if (pix_done) pixel_data <= pix_next;
      if (frame_next || gap_sync)
        pixel_index <= '0;
      else if (pixel_valid)
        pixel_index <= pixel_index + PIX_W'(1);
    end
  end
endmodule

// File: tb/tb_ws2812b_rx.sv
// Self-checking bench for ws2812b_rx: expected pixels queued at send time, compared on pixel_valid.
module tb_ws2812b_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [5:0]  pixel_index;
  logic        frame_done;
  logic        rx_error;

  typedef struct packed {
    logic [23:0] d;
    logic [5:0]  i;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] exp_idx = '0;
  int n_chk = 0, n_err = 0;
  int cyc = 0, n_frame = 0, n_rxerr = 0, fd_cyc = 0, pv_cyc = 0, err_cyc = 0;
  int exp_frames = 0, exp_errs = 0;

  always #5 clk = ~clk;

  ws2812b_rx dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .pixel_valid(pixel_valid),
    .pixel_data (pixel_data),
    .pixel_index(pixel_index),
    .frame_done (frame_done),
    .rx_error   (rx_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pixel_valid) begin
      pv_cyc = cyc;
      chk("pix_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pix_data", 32'(pixel_data), 32'(e.d));
        chk("pix_index", 32'(pixel_index), 32'(e.i));
      end
    end
    if (frame_done) begin
      n_frame++;
      fd_cyc = cyc;
    end
    if (rx_error) begin
      n_rxerr++;
      err_cyc = cyc;
    end
    if (frame_done || pixel_valid)
      chk("fd_pv_overlap", 32'(frame_done & pixel_valid), 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int n);
    din = v;
    tick(n);
  endtask

  task automatic send_bit(input logic b, input int h0, input int h1);
    int h;
    h = b ? h1 : h0;
    drive(1'b1, h);
    drive(1'b0, 15 - h);
  endtask

  task automatic send_bits(input logic [23:0] d, input int first, input int last);
    for (int i = first; i >= last; i--) send_bit(d[i], 4, 8);
  endtask

  task automatic send_pixel(input logic [23:0] d, input int h0, input int h1);
    exp_q.push_back({d, exp_idx});
    exp_idx = exp_idx + 6'd1;
    for (int i = 23; i >= 0; i--) send_bit(d[i], h0, h1);
  endtask

  task automatic gap();
    drive(1'b0, 700);
    exp_idx = '0;
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_frames"}, 32'(n_frame), 32'(exp_frames));
    chk({tag, "_errors"}, 32'(n_rxerr), 32'(exp_errs));
    chk({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    tick(4);
    @(negedge clk);
    chk("rst_valid", 32'(pixel_valid), 32'd0);
    chk("rst_data", 32'(pixel_data), 32'd0);
    chk("rst_index", 32'(pixel_index), 32'd0);
    chk("rst_frame", 32'(frame_done), 32'd0);
    chk("rst_error", 32'(rx_error), 32'd0);
    tick(1);
    rst = 1'b0;

    // single pixel after an initial sync gap
    drive(1'b0, 700);
    send_pixel(24'hFF0000, 4, 8);
    gap();
    exp_frames++;
    checkpoint("t1");

    // full 64-pixel frame, latch timing measured from the last commit
    for (int i = 0; i < 64; i++) send_pixel(24'(i), 4, 8);
    gap();
    exp_frames++;
    checkpoint("t2");
    chk("t2_latch_delay", 32'(fd_cyc - pv_cyc), 32'd599);

    // decode threshold and accepted width extremes; first pixel of the new frame is index 0
    send_pixel(24'h000000, 6, 8);
    send_pixel(24'h000001, 4, 7);
    send_pixel(24'hA5A5A5, 2, 12);
    send_pixel(24'h5A5A5A, 2, 12);
    gap();
    exp_frames++;
    checkpoint("t3");
    chk("t3_data_hold", 32'(pixel_data), 32'h5A5A5A);

    // over-long high mid-pixel, trailing traffic ignored until a full gap
    send_bits(24'hFFFFFF, 23, 19);
    drive(1'b1, 13);
    drive(1'b0, 11);
    exp_errs++;
    send_bits(24'hFFFFFF, 17, 0);
    gap();
    checkpoint("t4a");
    send_pixel(24'h123456, 4, 8);
    gap();
    exp_frames++;
    checkpoint("t4b");

    // glitch-short high
    send_bits(24'h000000, 23, 21);
    drive(1'b1, 1);
    drive(1'b0, 11);
    exp_errs++;
    send_bits(24'hFFFFFF, 19, 0);
    gap();
    checkpoint("t4c");
    send_pixel(24'h654321, 4, 8);
    gap();
    exp_frames++;
    checkpoint("t4d");

    // partial pixel at latch: frame_done and rx_error together
    send_bits(24'hABCDEF, 23, 14);
    gap();
    exp_frames++;
    exp_errs++;
    checkpoint("t5");
    chk("t5_same_cycle", 32'(fd_cyc), 32'(err_cyc));

    // reset mid-pixel
    send_pixel(24'h0F0F0F, 4, 8);
    send_bits(24'hF0F0F0, 23, 12);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(pixel_valid), 32'd0);
    chk("t6_data", 32'(pixel_data), 32'd0);
    chk("t6_index", 32'(pixel_index), 32'd0);
    chk("t6_frame", 32'(frame_done), 32'd0);
    chk("t6_error", 32'(rx_error), 32'd0);
    exp_idx = '0;
    send_bits(24'hF0F0F0, 11, 0);
    gap();
    checkpoint("t6a");
    send_pixel(24'hABCDEF, 4, 8);
    gap();
    exp_frames++;
    checkpoint("t6b");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
